// File: rtl/ysyx_22041071_rd_arbiter.sv
// Round-robin read-request arbiter between IFU and LSU in front of the AXI read master.
// One transaction in flight; returned beats are steered back to the owner combinationally.
module ysyx_22041071_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8,
    parameter int IFU_ID = 0,
    parameter int LSU_ID = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    input  logic [1:0]        ifu_req_size,
    input  logic [LEN_W-1:0]  ifu_req_len,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [1:0]        lsu_req_size,
    input  logic [LEN_W-1:0]  lsu_req_len,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,
    output logic [1:0]        ifu_rsp_resp,
    output logic              ifu_rsp_last,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic [1:0]        lsu_rsp_resp,
    output logic              lsu_rsp_last,
    output logic              mst_ar_valid,
    input  logic              mst_ar_ready,
    output logic [ID_W-1:0]   mst_id,
    output logic [ADDR_W-1:0] mst_addr,
    output logic [1:0]        mst_size,
    output logic [LEN_W-1:0]  mst_len,
    input  logic              mst_r_valid,
    input  logic [DATA_W-1:0] mst_r_data,
    input  logic [1:0]        mst_r_resp,
    input  logic              mst_r_last
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nxt;

    logic              last_lsu, own_lsu;
    logic [LEN_W-1:0]  beat_cnt, req_len;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [ID_W-1:0]   req_id;
    logic              pick_ifu, pick_lsu, grant, beat, cnt_hit, final_beat;
    logic [1:0]        beat_resp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        pick_ifu   = ifu_req_valid & (~lsu_req_valid | last_lsu);
        pick_lsu   = lsu_req_valid & (~ifu_req_valid | ~last_lsu);
        grant      = (state == IDLE) & ~reset & (ifu_req_valid | lsu_req_valid);
        beat       = (state == WAIT) & mst_r_valid;
        cnt_hit    = (beat_cnt == req_len);
        final_beat = beat & (mst_r_last | cnt_hit);
        // Master's last flag and our beat count must agree; otherwise flag the beat as SLVERR.
        beat_resp  = (mst_r_last != cnt_hit) ? 2'b10 : mst_r_resp;
        state_nxt  = state;
        case (state)
            IDLE:    if (ifu_req_valid | lsu_req_valid) state_nxt = ISSUE;
            ISSUE:   if (mst_ar_ready) state_nxt = WAIT;
            WAIT:    if (final_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_lsu <= 1'b1;
            own_lsu  <= 1'b0;
            beat_cnt <= '0;
            req_len  <= '0;
            req_addr <= '0;
            req_size <= '0;
            req_id   <= '0;
        end else begin
            if (grant) begin
                own_lsu  <= pick_lsu;
                last_lsu <= pick_lsu;
                req_addr <= pick_lsu ? lsu_req_addr : ifu_req_addr;
                req_size <= pick_lsu ? lsu_req_size : ifu_req_size;
                req_len  <= pick_lsu ? lsu_req_len  : ifu_req_len;
                req_id   <= pick_lsu ? ID_W'(LSU_ID) : ID_W'(IFU_ID);
                beat_cnt <= '0;
            end
            if (beat) beat_cnt <= final_beat ? '0 : beat_cnt + LEN_W'(1);
        end
    end

    assign ifu_req_ready = grant & pick_ifu;
    assign lsu_req_ready = grant & pick_lsu;

    assign mst_ar_valid = (state == ISSUE);
    assign mst_id       = req_id;
    assign mst_addr     = req_addr;
    assign mst_size     = req_size;
    assign mst_len      = req_len;

    // Response fields are gated so the idle requester sees all zeros.
    assign ifu_rsp_valid = beat & ~own_lsu;
    assign ifu_rsp_data  = ifu_rsp_valid ? mst_r_data : '0;
    assign ifu_rsp_resp  = ifu_rsp_valid ? beat_resp : 2'b00;
    assign ifu_rsp_last  = ifu_rsp_valid & final_beat;
    assign lsu_rsp_valid = beat & own_lsu;
    assign lsu_rsp_data  = lsu_rsp_valid ? mst_r_data : '0;
    assign lsu_rsp_resp  = lsu_rsp_valid ? beat_resp : 2'b00;
    assign lsu_rsp_last  = lsu_rsp_valid & final_beat;
endmodule

// File: tb/tb_ysyx_22041071_rd_arbiter.sv
// Randomized scoreboard bench for the IFU/LSU read arbiter with a behavioural read-master model.
module tb_ysyx_22041071_rd_arbiter;
    logic        clk = 0, reset = 1;
    logic        ifu_req_valid = 0, lsu_req_valid = 0;
    logic        ifu_req_ready, lsu_req_ready;
    logic [63:0] ifu_req_addr = 0, lsu_req_addr = 0;
    logic [1:0]  ifu_req_size = 0, lsu_req_size = 0;
    logic [7:0]  ifu_req_len = 0, lsu_req_len = 0;
    logic        ifu_rsp_valid, ifu_rsp_last, lsu_rsp_valid, lsu_rsp_last;
    logic [63:0] ifu_rsp_data, lsu_rsp_data;
    logic [1:0]  ifu_rsp_resp, lsu_rsp_resp;
    logic        mst_ar_valid, mst_ar_ready = 0;
    logic [3:0]  mst_id;
    logic [63:0] mst_addr;
    logic [1:0]  mst_size;
    logic [7:0]  mst_len;
    logic        mst_r_valid = 0, mst_r_last = 0;
    logic [63:0] mst_r_data = 0;
    logic [1:0]  mst_r_resp = 0;

    ysyx_22041071_rd_arbiter dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_req_size(ifu_req_size), .ifu_req_len(ifu_req_len),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_size(lsu_req_size), .lsu_req_len(lsu_req_len),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_resp(ifu_rsp_resp),
        .ifu_rsp_last(ifu_rsp_last),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_resp(lsu_rsp_resp),
        .lsu_rsp_last(lsu_rsp_last),
        .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready), .mst_id(mst_id), .mst_addr(mst_addr),
        .mst_size(mst_size), .mst_len(mst_len),
        .mst_r_valid(mst_r_valid), .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_last(mst_r_last)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [63:0] addr; logic [1:0] size; logic [7:0] len; } ar_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; } beat_t;
    ar_t   ar_q[$];
    beat_t rsp_q[$];

    int checks = 0, errors = 0;
    bit busy = 0, last_lsu = 1, tgt_lsu = 0;
    int slave_mode = -1, slave_stall = -1;
    int ifu_beats = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: arbitration model, AR check, response scoreboard.
    always @(negedge clk) begin
        bit exp_i, exp_l;
        if (reset) begin
            chk("rst_outputs", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_last,
                                lsu_rsp_last, mst_ar_valid, mst_id, mst_size, mst_len, ifu_rsp_resp, lsu_rsp_resp}, 0);
            chk("rst_fields", mst_addr | ifu_rsp_data | lsu_rsp_data, 0);
            ar_q.delete(); rsp_q.delete();
            busy = 0; last_lsu = 1;
        end else begin
            exp_i = !busy && ifu_req_valid && (!lsu_req_valid || last_lsu);
            exp_l = !busy && lsu_req_valid && (!ifu_req_valid || !last_lsu);
            chk("ifu_ready", ifu_req_ready, exp_i);
            chk("lsu_ready", lsu_req_ready, exp_l);
            if (exp_i || exp_l) begin
                busy = 1; tgt_lsu = exp_l; last_lsu = exp_l;
                if (exp_l) ar_q.push_back('{4'd1, lsu_req_addr, lsu_req_size, lsu_req_len});
                else       ar_q.push_back('{4'd0, ifu_req_addr, ifu_req_size, ifu_req_len});
            end
            if (mst_ar_valid) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    chk("ar_id", mst_id, ar_q[0].id);
                    chk("ar_addr", mst_addr, ar_q[0].addr);
                    chk("ar_size_len", {mst_size, mst_len}, {ar_q[0].size, ar_q[0].len});
                    if (mst_ar_ready) void'(ar_q.pop_front());
                end
            end
            if (ifu_rsp_valid || lsu_rsp_valid) begin
                chk("rsp_route", {ifu_rsp_valid, lsu_rsp_valid}, tgt_lsu ? 2'b01 : 2'b10);
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    beat_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_data", tgt_lsu ? lsu_rsp_data : ifu_rsp_data, e.data);
                    chk("rsp_resp", tgt_lsu ? lsu_rsp_resp : ifu_rsp_resp, e.resp);
                    chk("rsp_last", tgt_lsu ? lsu_rsp_last : ifu_rsp_last, e.last);
                    if (e.last) busy = 0;
                end
            end
        end
    end

    // Read-master model: optional AR stall with stray beats, then a burst whose last flag may misbehave.
    initial begin
        int stall, mode, len, k;
        bit lastf;
        beat_t e;
        forever begin
            @(posedge clk); #1;
            mst_ar_ready = 0; mst_r_valid = 0; mst_r_last = 0;
            if (!reset && mst_ar_valid) begin
                stall = (slave_stall >= 0) ? slave_stall : int'($urandom_range(0, 3));
                repeat (stall) begin
                    mst_r_valid = 1'($urandom_range(0, 1));
                    mst_r_last  = 1'($urandom_range(0, 1));
                    mst_r_data  = {$urandom, $urandom};
                    @(posedge clk); #1;
                    mst_r_valid = 0; mst_r_last = 0;
                end
                mst_ar_ready = 1;
                len = int'(mst_len);
                @(posedge clk); #1;
                mst_ar_ready = 0;
                if (slave_mode >= 0) mode = slave_mode;
                else begin
                    k = int'($urandom_range(0, 9));
                    mode = (k < 7) ? 0 : (k < 9) ? 1 : 2;
                end
                if (mode == 1 && len == 0) mode = 0;
                k = (mode == 1) ? int'($urandom_range(0, len - 1)) : -1;
                for (int i = 0; i <= len; i++) begin
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                    if (reset) break;
                    lastf = (mode == 0) ? (i == len) : (mode == 1) ? (i == k) : 1'b0;
                    mst_r_valid = 1; mst_r_last = lastf;
                    mst_r_data = {$urandom, $urandom};
                    mst_r_resp = 2'($urandom_range(0, 3));
                    e.data = mst_r_data;
                    e.last = lastf || (i == len);
                    e.resp = (lastf != (i == len)) ? 2'b10 : mst_r_resp;
                    rsp_q.push_back(e);
                    @(posedge clk); #1;
                    mst_r_valid = 0; mst_r_last = 0;
                    if (reset || e.last) break;
                end
            end else if (!reset) begin
                mst_r_valid = ($urandom_range(0, 7) == 0);
                mst_r_data  = {$urandom, $urandom};
            end
        end
    end

    task automatic set_ifu(input logic [63:0] a, input logic [1:0] s, input logic [7:0] l);
        ifu_req_valid = 1; ifu_req_addr = a; ifu_req_size = s; ifu_req_len = l;
    endtask
    task automatic set_lsu(input logic [63:0] a, input logic [1:0] s, input logic [7:0] l);
        lsu_req_valid = 1; lsu_req_addr = a; lsu_req_size = s; lsu_req_len = l;
    endtask

    // One cycle: observe handshakes, then drop (or re-arm) accepted requests after the edge.
    task automatic step(input bit rearm);
        bit ri, rl;
        @(negedge clk);
        ri = ifu_req_ready; rl = lsu_req_ready;
        if (ifu_rsp_valid) ifu_beats++;
        @(posedge clk); #1;
        if (ri) begin
            if (rearm) set_ifu({$urandom, $urandom}, 2'($urandom), 8'($urandom_range(0, 3)));
            else ifu_req_valid = 0;
        end
        if (rl) begin
            if (rearm) set_lsu({$urandom, $urandom}, 2'($urandom), 8'($urandom_range(0, 3)));
            else lsu_req_valid = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((ifu_req_valid || lsu_req_valid || busy) && n < 3000) begin step(0); n++; end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout busy=%0d ifu_v=%0d lsu_v=%0d", busy, ifu_req_valid, lsu_req_valid);
        end
        step(0); step(0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Single IFU request with a long AR stall.
        slave_mode = 0; slave_stall = 5;
        set_ifu(64'h8000_0000, 2'b11, 8'd0);
        drain();
        slave_stall = -1;

        // Back-to-back ties: IFU, LSU, IFU, LSU.
        set_ifu(64'h1000, 2'b10, 8'd1);
        set_lsu(64'h2000, 2'b01, 8'd0);
        repeat (40) step(1);
        drain();

        // LSU bursts: clean, early last, missing last, and the longest burst.
        set_lsu(64'h3000, 2'b11, 8'd3); drain();
        slave_mode = 1; set_lsu(64'h3100, 2'b11, 8'd3); drain();
        slave_mode = 2; set_lsu(64'h3200, 2'b11, 8'd3); drain();
        slave_mode = 2; set_ifu(64'h3300, 2'b00, 8'd0); drain();
        slave_mode = 0; set_lsu(64'h4000, 2'b11, 8'd255); drain();

        // Random traffic.
        slave_mode = -1;
        for (int c = 0; c < 400; c++) begin
            if (!ifu_req_valid && $urandom_range(0, 2) == 0)
                set_ifu({$urandom, $urandom}, 2'($urandom), 8'($urandom_range(0, 7)));
            if (!lsu_req_valid && $urandom_range(0, 2) == 0)
                set_lsu({$urandom, $urandom}, 2'($urandom), 8'($urandom_range(0, 7)));
            step(0);
        end
        drain();

        // Asynchronous reset in the middle of a len=7 IFU burst.
        slave_mode = 0;
        set_ifu(64'h5000, 2'b11, 8'd7);
        ifu_beats = 0; n = 0;
        while (ifu_beats < 2 && n < 200) begin step(0); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL reset_setup_timeout beats=%0d", ifu_beats);
        end
        #2 reset = 1;
        set_ifu(64'h6000, 2'b01, 8'd0);
        set_lsu(64'h7000, 2'b10, 8'd0);
        repeat (3) @(posedge clk);
        #1 reset = 0;
        drain();

        chk("rsp_q_empty", rsp_q.size(), 0);
        chk("ar_q_empty", ar_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ysyx_22041071_rd_arbiter.md
Name: ysyx_22041071_rd_arbiter

Overview:
- Two-master read-request arbiter sitting directly upstream of the AXI read master.
- Accepts independent read requests from the instruction-fetch unit (IFU) and the load/store unit (LSU) and grants one at a time, round-robin.
- Presents the granted request on the AXI read master's cpu-side request port, then steers the returned beats back to the granted requester.
- Only one transaction is outstanding at any time.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, read data width
- ID_W, 4, AXI ID width
- LEN_W, 8, burst length field width (beats-1)
- IFU_ID, 0, ID driven for IFU transactions
- LSU_ID, 1, ID driven for LSU transactions

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU request pending
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU address
- ifu_req_size  in  2  00=1B,01=2B,10=4B,11=8B
- ifu_req_len  in  LEN_W  IFU beats-1
- lsu_req_valid / lsu_req_ready / lsu_req_addr / lsu_req_size / lsu_req_len  same as IFU
- ifu_rsp_valid  out  1  one-cycle pulse per beat to IFU
- ifu_rsp_data  out  DATA_W  beat data
- ifu_rsp_resp  out  2  AXI resp
- ifu_rsp_last  out  1  final beat
- lsu_rsp_valid / lsu_rsp_data / lsu_rsp_resp / lsu_rsp_last  same as IFU
- mst_ar_valid  out  1  request to read master
- mst_ar_ready  in  1  read master idle/accepting
- mst_id  out  ID_W  transaction ID
- mst_addr  out  ADDR_W  address
- mst_size  out  2  size
- mst_len  out  LEN_W  beats-1
- mst_r_valid  in  1  one-cycle pulse per returned beat
- mst_r_data  in  DATA_W  beat data
- mst_r_resp  in  2  beat resp
- mst_r_last  in  1  final beat flag from master

Behaviour:
- Reset (async, reset=1):
  - state=IDLE, last_grant=LSU (so IFU wins the first tie), beat_cnt=0.
  - All outputs 0; all request registers 0.
- State machine:
  - IDLE -> ISSUE when any req_valid is high.
  - ISSUE -> WAIT when mst_ar_valid & mst_ar_ready.
  - WAIT -> IDLE on the final beat (definition below).
- IDLE arbitration:
  - Only one valid: grant it.
  - Both valid: grant the master that is not last_grant.
  - Grant cycle: the granted *_req_ready pulses high for exactly 1 cycle (combinational from IDLE and the grant decision); addr/size/len are latched and the ID is set to IFU_ID or LSU_ID.
  - last_grant updates on grant.
  - The non-granted *_req_ready stays 0.
- ISSUE:
  - mst_ar_valid=1 with the latched fields.
  - Fields are stable until the handshake.
  - mst_ar_valid deasserts the cycle after the handshake.
- WAIT, per mst_r_valid beat:
  - Route data/resp to the granted requester's *_rsp_* in the same cycle (combinational pass-through, zero latency).
  - The other requester's rsp_valid stays 0.
  - beat_cnt increments per beat.
- Final beat = mst_r_last=1 OR beat_cnt==latched len.
  - The routed *_rsp_last is 1 on the final beat.
  - If the two conditions disagree (last early, or count reached without last), the routed resp is forced to 2'b10 (SLVERR) on that beat and the transaction still terminates.
- Resp passes through unchanged otherwise.
- Requests arriving in ISSUE/WAIT are not accepted; the requester must hold valid.
- A new grant is possible in the cycle after returning to IDLE; there is no IDLE bypass in the completion cycle.
- mst_r_valid in IDLE/ISSUE is ignored: no rsp pulses and no state change.
- Reset mid-transaction returns to IDLE immediately; no response is emitted for the aborted transaction.
- len=0: a single beat completes the transaction.
- len=255: beat_cnt is 8 bits and must reach 255 without wrap.

Test Plan:
- Only IFU valid, addr=0x8000_0000, size=11, len=0 -> ifu_req_ready 1-cycle pulse; mst_ar_valid with id=0, addr=0x8000_0000; one beat data=0x1122334455667788 with last=1 -> ifu_rsp_valid/last=1, data matches, resp=00; lsu_rsp_valid stays 0; back to IDLE.
- IFU and LSU valid together from reset -> IFU granted first (id=0); after completion LSU granted (id=1); three back-to-back ties alternate IFU, LSU, IFU.
- LSU burst len=3, beats carry last only on the 4th -> four lsu_rsp_valid pulses, lsu_rsp_last only on the 4th, resp=00 throughout.
- LSU len=3, master asserts last on beat 2 -> beat 2 rsp_last=1, resp=10; state returns to IDLE; no further pulses.
- mst_ar_ready held 0 for 5 cycles in ISSUE -> mst_ar_valid and fields held stable for all 5 cycles; handshake on cycle 6; stray mst_r_valid during ISSUE produces no rsp pulse.
- reset asserted asynchronously mid-WAIT of a len=7 burst -> all outputs 0 immediately; after release, IFU is granted first on the next tie.
